// File: rtl/rx_packet_parser_if.sv
// rtl/rx_packet_parser_if.sv - FIFO read port and payload stream bundle for rx_packet_parser
interface rx_packet_parser_if;
    logic       rx_empty;
    logic [7:0] read_data;
    logic       ren;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        input  rx_empty, read_data, out_ready,
        output ren, out_data, out_valid, out_last
    );

    modport slave (
        output rx_empty, read_data, out_ready,
        input  ren, out_data, out_valid, out_last
    );
endinterface

// File: rtl/rx_packet_parser.sv
// rtl/rx_packet_parser.sv - SYNC/LEN/payload/CHK packet parser on the UART RX FIFO read side
// Optional inter-byte timeout enabled by defining RX_PKT_TIMEOUT_EN.
module rx_packet_parser #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         CNT_W       = 8,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    rx_packet_parser_if.master   bus,
    output logic                 pkt_err,
    output logic [CNT_W-1:0]     err_count,
    output logic                 busy
);
    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [8:0] MAX_LEN_B = 9'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_EVAL,
        S_DRAIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               rd_pend;
    logic               ren_c;
    logic               err_now;
    logic               pkt_state;
    logic               fetch_state;
    logic               len_ok;
    logic               handshake;
    logic               timeout_hit;
    logic [7:0]         b;
    logic [7:0]         chk;
    logic [7:0]         chk_rx;
    logic [IDX_W-1:0]   len_m1;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_inc;
    logic [7:0]         out_data_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic [7:0]         pbuf [MAX_LEN];

    assign b           = bus.read_data;
    assign idx_inc     = idx + 1'b1;
    assign pkt_state   = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    assign fetch_state = pkt_state || (state == S_HUNT);
    assign len_ok      = (b != 8'd0) && ({1'b0, b} <= MAX_LEN_B);
    assign handshake   = out_valid_q && bus.out_ready;
    assign busy        = (state != S_HUNT);

    // Strobe-style read: a byte requested this cycle is captured next cycle (rd_pend).
    assign ren_c = fetch_state && !bus.rx_empty && !rd_pend && !rst && !timeout_hit;
    assign bus.ren       = ren_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = out_valid_q && !rst;

`ifdef RX_PKT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] idle_cnt;

    assign timeout_hit = pkt_state && !rd_pend && (idle_cnt == TMO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (rst || !pkt_state || rd_pend || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_now   = 1'b0;
        case (state)
            S_HUNT: begin
                if (rd_pend && (b == SYNC_BYTE)) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (rd_pend) begin
                    if (len_ok) begin
                        state_nxt = S_PAYLOAD;
                    end else begin
                        err_now   = 1'b1;
                        state_nxt = S_HUNT;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rd_pend && (idx == len_m1)) state_nxt = S_CHK;
            end
            S_CHK: begin
                if (rd_pend) state_nxt = S_EVAL;
            end
            S_EVAL: begin
                if (chk_rx == chk) begin
                    state_nxt = S_DRAIN;
                end else begin
                    err_now   = 1'b1;
                    state_nxt = S_HUNT;
                end
            end
            S_DRAIN: begin
                if (handshake && out_last_q) state_nxt = S_HUNT;
            end
            default: state_nxt = S_HUNT;
        endcase
        if (timeout_hit) begin
            err_now   = 1'b1;
            state_nxt = S_HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == S_PAYLOAD) && rd_pend) begin
            pbuf[idx] <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend     <= 1'b0;
            idx         <= '0;
            len_m1      <= '0;
            chk         <= 8'd0;
            chk_rx      <= 8'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pkt_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            rd_pend <= ren_c;
            pkt_err <= err_now;
            if (err_now && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
            case (state)
                S_LEN: begin
                    if (rd_pend && len_ok) begin
                        len_m1 <= IDX_W'(b - 8'd1);
                        chk    <= b;
                        idx    <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (rd_pend) begin
                        chk <= chk ^ b;
                        if (idx != len_m1) idx <= idx_inc;
                    end
                end
                S_CHK: begin
                    if (rd_pend) chk_rx <= b;
                end
                S_EVAL: begin
                    // Preload the first byte so out_valid rises the cycle after EVAL.
                    if (chk_rx == chk) begin
                        idx         <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= pbuf[0];
                        out_last_q  <= (len_m1 == '0);
                    end
                end
                S_DRAIN: begin
                    if (handshake) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            idx         <= '0;
                        end else begin
                            idx        <= idx_inc;
                            out_data_q <= pbuf[idx_inc];
                            out_last_q <= (idx_inc == len_m1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
